// File: rtl/serial_negate_sched.sv
// Purpose : arbitrates two parallel requesters onto one bit-serial two's-complement
//           negation core, streams the word LSB-first and reassembles the result.
// Latency : accept at edge k, rsp_valid from cycle k+W+2 (one word per W+3 cycles).
// Backpressure: rsp_valid holds in DONE until rsp_ready; no request is accepted
//           outside IDLE, so reqN_ready stays low while a word is in flight.
//
// Ports:
//   t_clk, r                  clock, synchronous active-high reset
//   req0_* / req1_*           valid/ready request channels carrying W-bit operands
//   ser_i, ser_r, ser_y       serial core interface (data in, clear, Mealy result)
//   rsp_valid/ready/data/id   result channel, rsp_id names the owning requester
//   busy                      high whenever the sequencer is not in IDLE
// Optional: define SERIAL_NEGATE_OVF_EN to add rsp_ovf, flagging the operand
//           2^(W-1) whose negation is not representable.
module serial_negate_sched #(
    parameter int unsigned W = 8
) (
    input  logic         t_clk,
    input  logic         r,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         ser_i,
    output logic         ser_r,
    input  logic         ser_y,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
`ifdef SERIAL_NEGATE_OVF_EN
    output logic         rsp_ovf,
`endif
    input  logic         rsp_ready,
    output logic         busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            id_q, id_d;
    logic            last_grant_q, last_grant_d;
    logic            grant0, grant1;

`ifdef SERIAL_NEGATE_OVF_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    logic            ovf_q, ovf_d;
`endif

    // Grant and next-state logic. When both requesters are valid the one that
    // was not granted last wins; last_grant resets to 1 so requester 0 goes first.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
`ifdef SERIAL_NEGATE_OVF_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant_q)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    shift_d      = grant1 ? req1_data : req0_data;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = CLEAR;
`ifdef SERIAL_NEGATE_OVF_EN
                    ovf_d        = (grant1 ? req1_data : req0_data) == MOST_NEG;
`endif
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // The core is Mealy: ser_y already reflects the bit on ser_i this
                // cycle, so it is captured on the same edge the bit is consumed.
                result_d = {ser_y, result_q[W-1:1]};
                shift_d  = shift_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef SERIAL_NEGATE_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
`ifdef SERIAL_NEGATE_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    // Ready is gated by r so a requester never sees an acceptance that reset discards.
    assign req0_ready = grant0 & ~r;
    assign req1_ready = grant1 & ~r;

    // Reset also clears the core so a word aborted mid-stream leaves no stale carry.
    assign ser_r     = r | (state_q == CLEAR);
    assign ser_i     = (state_q == SHIFT) & shift_q[0];

    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = result_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);
`ifdef SERIAL_NEGATE_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_negate_sched.sv
// Bench for serial_negate_sched with a behavioural model of the serial core.
// Stimulus records the hand-computed result per requester; an acceptance monitor
// pushes it into the scoreboard, and a response monitor pops and compares.
module tb_serial_negate_sched;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         ser_i, ser_r, ser_y;
    logic         rsp_valid, rsp_id, rsp_ready, busy;
    logic [W-1:0] rsp_data;
`ifdef SERIAL_NEGATE_OVF_EN
    logic         rsp_ovf;
`endif

    serial_negate_sched #(.W(W)) dut (
        .t_clk      (t_clk),
        .r          (r),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_i      (ser_i),
        .ser_r      (ser_r),
        .ser_y      (ser_y),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
`ifdef SERIAL_NEGATE_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 t_clk = ~t_clk;

    // Serial two's-complement core: copy bits up to and including the first 1,
    // invert every bit after it.
    logic seen_q = 1'b0;
    always @(posedge t_clk) begin
        if (ser_r)      seen_q <= 1'b0;
        else if (ser_i) seen_q <= 1'b1;
    end
    assign ser_y = ser_i ^ seen_q;

    typedef struct {
        logic [W-1:0] data;
        logic         id;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] op_q[$];
    exp_t         pend0, pend1;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_rsp   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Acceptance monitor: an accepted word enqueues its expected response and operand.
    always @(negedge t_clk) begin
        if (req0_ready === 1'b1) begin
            exp_q.push_back(pend0);
            op_q.push_back(req0_data);
        end
        if (req1_ready === 1'b1) begin
            exp_q.push_back(pend1);
            op_q.push_back(req1_data);
        end
    end

    // Response monitor.
    always @(negedge t_clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got data 0x%0h id %0d, required no response", rsp_data, rsp_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_id", rsp_id, e.id);
`ifdef SERIAL_NEGATE_OVF_EN
                chk("rsp_ovf", rsp_ovf, e.ovf);
`endif
            end
        end
    end

    // Serial stream check: W operand bits LSB-first right after the clear cycle.
    initial begin
        logic [W-1:0] op;
        forever begin
            @(negedge t_clk);
            if (ser_r === 1'b1 && r === 1'b0) begin
                if (op_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ser_clear: got core clear, required an accepted operand first");
                end else begin
                    op = op_q.pop_front();
                    for (int i = 0; i < W; i++) begin
                        @(negedge t_clk);
                        if (r === 1'b1) break;
                        chk($sformatf("ser_i_bit%0d", i), ser_i, op[i]);
                        chk("ser_r_in_shift", ser_r, 1'b0);
                    end
                end
            end else if (busy === 1'b0) begin
                chk("ser_i_idle", ser_i, 1'b0);
            end
        end
    end

    task automatic wait_any(output int who);
        who = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge t_clk);
            if (req0_ready === 1'b1) begin who = 0; return; end
            if (req1_ready === 1'b1) begin who = 1; return; end
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no ready pulse in 100 cycles, required one");
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200; c++) begin
            @(negedge t_clk);
            if (exp_q.size() == 0 && busy === 1'b0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
    endtask

    task automatic do_reset(input int cycles);
        @(posedge t_clk); #1;
        r = 1'b1;
        repeat (cycles) @(posedge t_clk);
        #1 r = 1'b0;
    endtask

    task automatic send_one(input logic id, input logic [W-1:0] d,
                            input logic [W-1:0] res, input logic ovf);
        int who;
        @(posedge t_clk); #1;
        if (id) begin
            pend1 = '{res, 1'b1, ovf}; req1_data = d; req1_valid = 1'b1;
        end else begin
            pend0 = '{res, 1'b0, ovf}; req0_data = d; req0_valid = 1'b1;
        end
        wait_any(who);
        chk("grant_who", who, id);
        @(posedge t_clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int who, lat, bad_busy, bad_rdy;
        logic [W-1:0] held;

        r = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'h33; req1_data = 8'h44; rsp_ready = 1'b1;
        pend0 = '{8'h00, 1'b0, 1'b0}; pend1 = '{8'h00, 1'b1, 1'b0};

        // Reset: ready outputs stay low even with valid requests, core is cleared.
        repeat (2) begin
            @(negedge t_clk);
            chk("rst_req0_ready", req0_ready, 1'b0);
            chk("rst_req1_ready", req1_ready, 1'b0);
            chk("rst_ser_r", ser_r, 1'b1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge t_clk); #1 r = 1'b0;
        @(negedge t_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_ser_i", ser_i, 1'b0);
        chk("rst_ser_r_released", ser_r, 1'b0);

        // Single word with latency, busy and one-cycle ready pulse checks.
        @(posedge t_clk); #1;
        pend0 = '{8'hFB, 1'b0, 1'b0}; req0_data = 8'h05; req0_valid = 1'b1;
        wait_any(who);
        chk("t1_grant", who, 0);
        lat = 0; bad_busy = 0; bad_rdy = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge t_clk);
            if (busy !== 1'b1) bad_busy++;
            if (req0_ready !== 1'b0) bad_rdy++;
            if (rsp_valid === 1'b1) begin lat = c; break; end
        end
        chk("t1_latency", lat, 10);
        chk("t1_busy_low_cycles", bad_busy, 0);
        chk("t1_extra_ready", bad_rdy, 0);
        @(posedge t_clk); #1 req0_valid = 1'b0;
        wait_drain();

        // Simultaneous requests after reset: req0 first, then req1 wins over a re-presented req0.
        do_reset(2);
        @(posedge t_clk); #1;
        pend0 = '{8'hFF, 1'b0, 1'b0}; req0_data = 8'h01; req0_valid = 1'b1;
        pend1 = '{8'hF0, 1'b1, 1'b0}; req1_data = 8'h10; req1_valid = 1'b1;
        wait_any(who);
        chk("t2_first", who, 0);
        @(posedge t_clk); #1;
        pend0 = '{8'hFE, 1'b0, 1'b0}; req0_data = 8'h02;
        wait_any(who);
        chk("t2_second", who, 1);
        @(posedge t_clk); #1 req1_valid = 1'b0;
        wait_any(who);
        chk("t2_third", who, 0);
        @(posedge t_clk); #1 req0_valid = 1'b0;
        wait_drain();

        // Arithmetic edge cases.
        send_one(1'b1, 8'h80, 8'h80, 1'b1);
        send_one(1'b0, 8'h7F, 8'h81, 1'b0);

        // Backpressure: result held in DONE, pending req1 waits for the handshake.
        @(posedge t_clk); #1;
        rsp_ready = 1'b0;
        pend0 = '{8'h00, 1'b0, 1'b0}; req0_data = 8'h00; req0_valid = 1'b1;
        wait_any(who);
        chk("t4_grant", who, 0);
        @(posedge t_clk); #1;
        req0_valid = 1'b0;
        pend1 = '{8'hC4, 1'b1, 1'b0}; req1_data = 8'h3C; req1_valid = 1'b1;
        lat = 0;
        for (int c = 0; c < 40 && lat == 0; c++) begin
            @(negedge t_clk);
            if (rsp_valid === 1'b1) lat = 1;
        end
        chk("t4_reached_done", lat, 1);
        held = rsp_data;
        chk("t4_data", held, 8'h00);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge t_clk);
            chk("t4_hold_valid", rsp_valid, 1'b1);
            chk("t4_hold_data", rsp_data, 8'h00);
            chk("t4_hold_r0", req0_ready, 1'b0);
            chk("t4_hold_r1", req1_ready, 1'b0);
        end
        @(posedge t_clk); #1 rsp_ready = 1'b1;
        @(negedge t_clk);
        chk("t4_hs_r1", req1_ready, 1'b0);
        @(negedge t_clk);
        chk("t4_after_hs_r1", req1_ready, 1'b1);
        @(posedge t_clk); #1 req1_valid = 1'b0;
        wait_drain();

        // Reset mid-stream at bit 3 of 0x5A: aborted without a response, then retried.
        lat = n_rsp;
        @(posedge t_clk); #1;
        pend0 = '{8'hA6, 1'b0, 1'b0}; req0_data = 8'h5A; req0_valid = 1'b1;
        wait_any(who);
        chk("t5_grant", who, 0);
        @(posedge t_clk); #1 req0_valid = 1'b0;
        repeat (3) @(posedge t_clk);
        #1 r = 1'b1;
        @(negedge t_clk);
        chk("t5_ser_r_in_reset", ser_r, 1'b1);
        exp_q.delete();
        @(posedge t_clk); #1 r = 1'b0;
        @(negedge t_clk);
        chk("t5_busy_after_rst", busy, 1'b0);
        chk("t5_valid_after_rst", rsp_valid, 1'b0);
        repeat (15) @(negedge t_clk);
        chk("t5_no_response", n_rsp, lat);
        send_one(1'b0, 8'h5A, 8'hA6, 1'b0);
        chk("t5_retry_response", n_rsp, lat + 1);

        chk("end_scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
